// File: rtl/dbuf_ctrl.sv
// dbuf_ctrl: single-port access controller and ring-buffer sequencer.
// Shares one read/write port of the sample buffer between the capture
// writer and the host reader, keeping pointers, fill count and status.
module dbuf_ctrl #(
  parameter int DEPTH = 49152,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          wr_valid_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          wr_ready_o,
  input  logic          rd_req_i,
  output logic          rd_ack_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic [DW-1:0] buf_din_o,
  output logic [AW-1:0] buf_didx_o,
  output logic          buf_rw_o,
  input  logic [DW-1:0] buf_di_i,
  output logic [AW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          overflow_o
);

  // Which side won the most recent contention; reset to read so the
  // writer takes the first contested cycle.
  typedef enum logic {
    WIN_READ  = 1'b0,
    WIN_WRITE = 1'b1
  } win_e;

  localparam logic [AW-1:0] LastIdx  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] DepthCnt = AW'(DEPTH);

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [AW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  win_e          lastWin_q, lastWin_d;
  logic          bufRw_q, bufRw_d;
  logic [AW-1:0] bufDidx_q, bufDidx_d;
  logic [DW-1:0] bufDin_q, bufDin_d;
  logic          rdPend_q, rdPend_d;
  logic          rdValid_q;

  logic          isFull;
  logic          isEmpty;
  logic          wrElig;
  logic          rdElig;
  logic          wrGrant;
  logic          rdGrant;

  // Ring pointer advance: the last buffer word wraps back to word 0.
  function automatic logic [AW-1:0] nextPtr(input logic [AW-1:0] ptr);
    return (ptr == LastIdx) ? '0 : ptr + 1'b1;
  endfunction

  assign isFull  = (count_q == DepthCnt);
  assign isEmpty = (count_q == '0);

  // A clear cycle blocks both sides so nothing is granted while state resets.
  assign wrElig = wr_valid_i & ~isFull & ~clr_i;
  assign rdElig = rd_req_i & ~isEmpty & ~clr_i;

  // Arbitrate the single port; alternate winners only when both sides compete.
  always_comb begin
    wrGrant   = 1'b0;
    rdGrant   = 1'b0;
    lastWin_d = lastWin_q;
    if (wrElig && rdElig) begin
      if (lastWin_q == WIN_READ) begin
        wrGrant   = 1'b1;
        lastWin_d = WIN_WRITE;
      end else begin
        rdGrant   = 1'b1;
        lastWin_d = WIN_READ;
      end
    end else begin
      wrGrant = wrElig;
      rdGrant = rdElig;
    end
  end

  // Next-state for pointers, count, status and the registered buffer port.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    bufRw_d    = 1'b0;
    bufDidx_d  = bufDidx_q;
    bufDin_d   = bufDin_q;
    rdPend_d   = rdGrant;
    if (clr_i) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (wr_valid_i && isFull) begin
        overflow_d = 1'b1;
      end
      if (wrGrant) begin
        bufRw_d   = 1'b1;
        bufDidx_d = wrPtr_q;
        bufDin_d  = wr_data_i;
        wrPtr_d   = nextPtr(wrPtr_q);
        count_d   = count_q + 1'b1;
      end else if (rdGrant) begin
        bufDidx_d = rdPtr_q;
        rdPtr_d   = nextPtr(rdPtr_q);
        count_d   = count_q - 1'b1;
      end
    end
  end

  // State registers; an async reset also drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      lastWin_q  <= WIN_READ;
      bufRw_q    <= 1'b0;
      bufDidx_q  <= '0;
      bufDin_q   <= '0;
      rdPend_q   <= 1'b0;
      rdValid_q  <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      lastWin_q  <= lastWin_d;
      bufRw_q    <= bufRw_d;
      bufDidx_q  <= bufDidx_d;
      bufDin_q   <= bufDin_d;
      rdPend_q   <= rdPend_d;
      rdValid_q  <= rdPend_q;
    end
  end

  assign wr_ready_o = wrGrant;
  assign rd_ack_o   = rdGrant;
  assign rd_valid_o = rdValid_q;
  assign rd_data_o  = buf_di_i;
  assign buf_din_o  = bufDin_q;
  assign buf_didx_o = bufDidx_q;
  assign buf_rw_o   = bufRw_q;
  assign count_o    = count_q;
  assign full_o     = isFull;
  assign empty_o    = isEmpty;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_dbuf_ctrl.sv
// tb_dbuf_ctrl: directed bench for dbuf_ctrl with a behavioural buffer
// memory and a FIFO scoreboard for read data and read latency.
module tb_dbuf_ctrl;

  localparam int Depth = 49152;

  logic        clk;
  logic        rstN;
  logic        clr;
  logic        wrValid;
  logic [31:0] wrData;
  logic        wrReady;
  logic        rdReq;
  logic        rdAck;
  logic        rdValid;
  logic [31:0] rdData;
  logic [31:0] bufDin;
  logic [15:0] bufDidx;
  logic        bufRw;
  logic [31:0] bufDi;
  logic [15:0] count;
  logic        full;
  logic        empty;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:Depth-1];
  logic [31:0] modelQ [$];
  logic [31:0] expQ [$];
  logic        ackD1;
  logic        ackD2;

  dbuf_ctrl dut (
    .clk        (clk),
    .rst_n      (rstN),
    .clr_i      (clr),
    .wr_valid_i (wrValid),
    .wr_data_i  (wrData),
    .wr_ready_o (wrReady),
    .rd_req_i   (rdReq),
    .rd_ack_o   (rdAck),
    .rd_valid_o (rdValid),
    .rd_data_o  (rdData),
    .buf_din_o  (bufDin),
    .buf_didx_o (bufDidx),
    .buf_rw_o   (bufRw),
    .buf_di_i   (bufDi),
    .count_o    (count),
    .full_o     (full),
    .empty_o    (empty),
    .overflow_o (overflow)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port buffer with a one-cycle registered read.
  always @(posedge clk) begin
    if (bufRw) mem[bufDidx] <= bufDin;
    bufDi <= mem[bufDidx];
  end

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive all inputs for the coming cycle and let combinational outputs settle.
  task automatic applyStimulus(input logic wv, input logic [31:0] wd, input logic rr, input logic cl);
    wrValid = wv;
    wrData  = wd;
    rdReq   = rr;
    clr     = cl;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sampled on the falling edge; checks read latency and data order.
  always @(negedge clk) begin
    if (!rstN) begin
      modelQ.delete();
      expQ.delete();
      ackD1 = 1'b0;
      ackD2 = 1'b0;
    end else begin
      checkOutput("one_grant", {31'd0, wrReady & rdAck}, 32'd0);
      checkOutput("rd_valid_latency", {31'd0, rdValid}, {31'd0, ackD2});
      if (rdValid) begin
        checkOutput("rd_expected", {31'd0, expQ.size() > 0}, 32'd1);
        if (expQ.size() > 0) checkOutput("rd_data", rdData, expQ.pop_front());
      end
      ackD2 = ackD1;
      ackD1 = rdAck;
      if (wrReady) modelQ.push_back(wrData);
      if (rdAck) begin
        checkOutput("ack_has_data", {31'd0, modelQ.size() > 0}, 32'd1);
        if (modelQ.size() > 0) expQ.push_back(modelQ.pop_front());
      end
      if (clr) modelQ.delete();
    end
  end

  // Guard against a stuck run.
  initial begin
    repeat (110000) @(posedge clk);
    $display("[TB] FAIL watchdog: cycle budget expired, got %0d checks, expected completion", checks);
    $fatal(1, "[TB] watchdog");
  end

  // Directed test sequence.
  initial begin
    logic [31:0] wd;
    logic [3:0]  altW;
    logic [15:0] altCnt [0:3];
    altW = 4'b0101;
    altCnt[0] = 16'd11;
    altCnt[1] = 16'd10;
    altCnt[2] = 16'd11;
    altCnt[3] = 16'd10;

    rstN = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_count", {16'd0, count}, 32'd0);
    checkOutput("rst_empty", {31'd0, empty}, 32'd1);
    checkOutput("rst_full", {31'd0, full}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("rst_buf_rw", {31'd0, bufRw}, 32'd0);
    checkOutput("rst_buf_didx", {16'd0, bufDidx}, 32'd0);
    checkOutput("rst_buf_din", bufDin, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rdValid}, 32'd0);
    rstN = 1'b1;
    waitCycle();

    $display("[TB] four writes");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
      checkOutput("w4_ready", {31'd0, wrReady}, 32'd1);
      waitCycle();
      checkOutput("w4_buf_rw", {31'd0, bufRw}, 32'd1);
      checkOutput("w4_buf_didx", {16'd0, bufDidx}, 32'(i));
      checkOutput("w4_buf_din", bufDin, 32'hA0 + 32'(i));
      checkOutput("w4_count", {16'd0, count}, 32'(i + 1));
    end
    checkOutput("w4_empty", {31'd0, empty}, 32'd0);

    $display("[TB] four reads");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("r4_ack", {31'd0, rdAck}, 32'd1);
      waitCycle();
      checkOutput("r4_buf_rw", {31'd0, bufRw}, 32'd0);
      checkOutput("r4_buf_didx", {16'd0, bufDidx}, 32'(i));
      checkOutput("r4_count", {16'd0, count}, 32'(3 - i));
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("r5_no_ack", {31'd0, rdAck}, 32'd0);
    checkOutput("r4_empty", {31'd0, empty}, 32'd1);
    waitCycle();
    checkOutput("idle_didx_hold", {16'd0, bufDidx}, 32'd3);
    checkOutput("idle_din_hold", bufDin, 32'hA3);
    checkOutput("idle_rw", {31'd0, bufRw}, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) waitCycle();

    $display("[TB] alternation");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
      checkOutput("w10_ready", {31'd0, wrReady}, 32'd1);
      waitCycle();
    end
    checkOutput("w10_count", {16'd0, count}, 32'd10);
    wd = 32'hD0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, wd, 1'b1, 1'b0);
      checkOutput("alt_wr_ready", {31'd0, wrReady}, {31'd0, altW[k]});
      checkOutput("alt_rd_ack", {31'd0, rdAck}, {31'd0, ~altW[k]});
      if (wrReady) wd = wd + 32'd1;
      waitCycle();
      checkOutput("alt_count", {16'd0, count}, {16'd0, altCnt[k]});
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (3) waitCycle();

    $display("[TB] clear to realign pointers");
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    waitCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("clr1_count", {16'd0, count}, 32'd0);
    checkOutput("clr1_empty", {31'd0, empty}, 32'd1);

    $display("[TB] fill to full");
    for (int i = 0; i < Depth; i++) begin
      applyStimulus(1'b1, 32'hC000_0000 | 32'(i), 1'b0, 1'b0);
      checkOutput("fill_ready", {31'd0, wrReady}, 32'd1);
      waitCycle();
    end
    checkOutput("fill_last_didx", {16'd0, bufDidx}, 32'(Depth - 1));
    checkOutput("fill_count", {16'd0, count}, 32'(Depth));
    checkOutput("fill_full", {31'd0, full}, 32'd1);
    checkOutput("fill_empty", {31'd0, empty}, 32'd0);
    checkOutput("fill_overflow", {31'd0, overflow}, 32'd0);

    applyStimulus(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
    checkOutput("ovf_ready", {31'd0, wrReady}, 32'd0);
    waitCycle();
    checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_count", {16'd0, count}, 32'(Depth));
    checkOutput("ovf_buf_rw", {31'd0, bufRw}, 32'd0);

    applyStimulus(1'b1, 32'hEEEE_EEEE, 1'b1, 1'b0);
    checkOutput("full_rd_ack", {31'd0, rdAck}, 32'd1);
    checkOutput("full_wr_ready", {31'd0, wrReady}, 32'd0);
    waitCycle();
    checkOutput("after_rd_full", {31'd0, full}, 32'd0);
    checkOutput("after_rd_count", {16'd0, count}, 32'(Depth - 1));
    applyStimulus(1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0);
    checkOutput("wrap_wr_ready", {31'd0, wrReady}, 32'd1);
    waitCycle();
    checkOutput("wrap_wr_didx", {16'd0, bufDidx}, 32'd0);
    checkOutput("wrap_wr_rw", {31'd0, bufRw}, 32'd1);
    checkOutput("wrap_wr_din", bufDin, 32'hEEEE_EEEE);
    checkOutput("wrap_full", {31'd0, full}, 32'd1);
    checkOutput("ovf_sticky", {31'd0, overflow}, 32'd1);

    $display("[TB] drain across read-pointer wrap");
    for (int j = 0; j < Depth; j++) begin
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
      checkOutput("drain_ack", {31'd0, rdAck}, 32'd1);
      waitCycle();
      if (j == Depth - 2) checkOutput("drain_didx_last", {16'd0, bufDidx}, 32'(Depth - 1));
      if (j == Depth - 1) checkOutput("drain_didx_wrap", {16'd0, bufDidx}, 32'd0);
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("drain_empty", {31'd0, empty}, 32'd1);
    checkOutput("drain_count", {16'd0, count}, 32'd0);
    repeat (3) waitCycle();

    $display("[TB] clear with read in flight");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hF0 + 32'(i), 1'b0, 1'b0);
      checkOutput("pre_clr_ready", {31'd0, wrReady}, 32'd1);
      waitCycle();
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0);
    checkOutput("pre_clr_ack", {31'd0, rdAck}, 32'd1);
    waitCycle();
    applyStimulus(1'b1, 32'hF2, 1'b1, 1'b1);
    checkOutput("clr_no_wr", {31'd0, wrReady}, 32'd0);
    checkOutput("clr_no_rd", {31'd0, rdAck}, 32'd0);
    checkOutput("clr_ovf_before", {31'd0, overflow}, 32'd1);
    waitCycle();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0);
    checkOutput("clr_rd_valid", {31'd0, rdValid}, 32'd1);
    checkOutput("clr_rd_data", rdData, 32'hF0);
    checkOutput("clr_count", {16'd0, count}, 32'd0);
    checkOutput("clr_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("clr_empty", {31'd0, empty}, 32'd1);
    checkOutput("clr_buf_rw", {31'd0, bufRw}, 32'd0);
    repeat (3) waitCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbuf_ctrl.md
# dbuf_ctrl

Single-port access controller and ring-buffer sequencer for the 32-bit × 49152-word sample buffer. It shares the buffer's one read/write port between the PDM capture writer and the host readout reader, and keeps write and read pointers, a fill count and full/empty/overflow status. It drives the buffer's din/didx/RW inputs from registers and returns read data using the buffer's 1-cycle registered read.

## Interface
- DEPTH, 49152, buffer words; pointers wrap at DEPTH-1
- AW, 16, address/count width
- DW, 32, data width
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of pointers, count and overflow
- wr_valid  in  1  capture sample present; held until accepted
- wr_data  in  DW  capture sample
- wr_ready  out  1  combinational; write accepted this cycle
- rd_req  in  1  reader requests next word; held until acknowledged
- rd_ack  out  1  combinational; read accepted this cycle
- rd_valid  out  1  registered; rd_data valid this cycle
- rd_data  out  DW  equals buf_di
- buf_din  out  DW  registered buffer write data
- buf_didx  out  AW  registered buffer address
- buf_rw  out  1  registered; 1 write, 0 read
- buf_di  in  DW  buffer registered read data
- count  out  AW  words stored, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky; sample offered while full

## Operation
- Eligibility: write eligible = wr_valid & !full & !clr; read eligible = rd_req & !empty & !clr.
- Arbitration (one access per cycle): only one eligible → it is granted. Both eligible → grant the side not granted at the last contention (last_win register; updates only on contention). Reset value of last_win = read, so the writer wins the first contention.
- wr_ready = write grant; rd_ack = read grant.
- Write grant: register buf_rw=1, buf_didx=wptr, buf_din=wr_data; wptr advances (DEPTH-1 → 0); count +1.
- Read grant: register buf_rw=0, buf_didx=rptr; rptr advances with the same wrap rule; count −1; schedule rd_valid.
- No grant: buf_rw=0; buf_didx and buf_din hold their values. An idle read has no side effects.
- count changes by at most 1 per cycle. Reads and writes never occur in the same cycle.
- Overflow: wr_valid & full & !clr sets overflow. The sample is not written, and the writer observes wr_ready=0. overflow clears only on clr or reset.
- clr: wptr, rptr, count, overflow go to 0 on the next edge. No grants occur in the clr cycle. A read already in flight still produces its rd_valid.

## Timing
- Reset (async assert): buf_rw=0, buf_didx=0, buf_din=0, rd_valid=0, count=0, empty=1, full=0, overflow=0, pointers 0, last_win=read.
- Write granted in cycle C (edge E0 ends C): buf_* driven during C+1; memory updated at E1.
- Read granted in cycle C: buf_didx=rptr during C+1. The buffer registers data at E1. rd_valid=1 and rd_data valid during C+2. Latency is 2 cycles from rd_ack.
- Back-to-back reads: one word per cycle, rd_valid contiguous.
- full, empty and count are registered and reflect all grants up to the previous edge. A reader seeing empty=0 is granted at most count reads before empty re-evaluates.
- Reset mid-read: the pending rd_valid is discarded (goes 0 immediately).

## Test plan
- Reset then 4 writes 0xA0..0xA3 with no reads → wr_ready=1 each cycle; buf_didx 0..3 with buf_rw=1; count=4; empty=0.
- Then read 4 → rd_ack on 4 consecutive cycles; rd_valid 2 cycles after each ack; rd_data 0xA0,0xA1,0xA2,0xA3; count=0; empty=1; a 5th rd_req gets no rd_ack.
- wr_valid and rd_req both held with count=10 → grants alternate W,R,W,R starting with W after reset; count oscillates 11,10,11,10.
- Fill to 49152 → full=1, wr_ready=0. One further wr_valid → overflow=1 and count stays 49152. One read → full=0, and the next write lands at didx 0 (wrap).
- Pointer wrap: reads wrap rptr 49151→0 with data intact across the boundary.
- clr asserted with a read in flight and overflow=1 → that rd_valid still appears. Next cycle count=0, overflow=0, empty=1, and no grants in the clr cycle.
